// File: rtl/ldm_stm_sequencer_if.sv
// Control-word / sequencer bus for the LDM/STM register-list sequencer.
// The master side is the microprogrammed control unit; the slave side is the sequencer.
interface ldm_stm_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              LOAD;
  logic              STEP;
  logic [31:0]       IR;
  logic [ADDR_W-1:0] BASE;
  logic [3:0]        REG_NUM;
  logic [ADDR_W-1:0] ADDR;
  logic [4:0]        CNT;
  logic [ADDR_W-1:0] WB_ADDR;
  logic              READY;
  logic              MLS0;
  logic              MLS1;

  modport master (
    output LOAD, STEP, IR, BASE,
    input  REG_NUM, ADDR, CNT, WB_ADDR, READY, MLS0, MLS1
  );

  modport slave (
    input  LOAD, STEP, IR, BASE,
    output REG_NUM, ADDR, CNT, WB_ADDR, READY, MLS0, MLS1
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM register-list sequencer: walks the captured list lowest register first,
// presenting one register number and memory address per transfer step.
//
// state | meaning
// IDLE  | no sequence active, waiting for LOAD
// CALC  | one cycle: count list bits, compute start and writeback addresses
// XFER  | REG_NUM/ADDR valid, waiting for STEP per transfer
// DONE  | one cycle after the last transfer (or an empty list), then IDLE
module ldm_stm_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input logic             CLK,
  input logic             RESET,
  ldm_stm_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic              p_q, p_d;
  logic              u_q, u_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

  logic [4:0]        pop;
  logic [3:0]        low_idx;
  logic [15:0]       list_minus1;
  logic              one_left;
  logic [ADDR_W-1:0] word;
  logic [ADDR_W-1:0] span;

  // Only the list, P and U bits of IR matter here.
  logic unused_ir;
  assign unused_ir = ^{bus.IR[31:25], bus.IR[22:16]};

  // List decode: bit count, lowest remaining register, single-bit detect.
  always_comb begin
    pop     = 5'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + {4'd0, list_q[i]};
    end
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = 4'(i);
    end
    list_minus1 = list_q - 16'd1;
    one_left    = (list_q != 16'd0) && ((list_q & list_minus1) == 16'd0);
    word        = ADDR_W'(WORD_BYTES);
    span        = ADDR_W'(pop) * word;
  end

  // Next-state and datapath; LOAD overrides everything but reset.
  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    p_d       = p_q;
    u_d       = u_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wb_addr_d = wb_addr_q;
    if (bus.LOAD) begin
      state_d = S_CALC;
      list_d  = bus.IR[15:0];
      p_d     = bus.IR[24];
      u_d     = bus.IR[23];
      base_d  = bus.BASE;
    end else begin
      case (state_q)
        S_CALC: begin
          cnt_d     = pop;
          wb_addr_d = u_q ? base_q + span : base_q - span;
          // Transfers always run upward in address, so decrementing modes start low.
          case ({p_q, u_q})
            2'b01:   addr_d = base_q;
            2'b11:   addr_d = base_q + word;
            2'b00:   addr_d = base_q - span + word;
            default: addr_d = base_q - span;
          endcase
          state_d = (list_q == 16'd0) ? S_DONE : S_XFER;
        end
        S_XFER: begin
          if (bus.STEP) begin
            list_d = list_q & list_minus1;
            addr_d = addr_q + word;
            if (one_left) state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      list_q    <= 16'd0;
      p_q       <= 1'b0;
      u_q       <= 1'b0;
      base_q    <= '0;
      cnt_q     <= 5'd0;
      addr_q    <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      p_q       <= p_d;
      u_q       <= u_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  // Output decode; the list is empty in IDLE/DONE so REG_NUM settles at 0 there.
  always_comb begin
    bus.REG_NUM = low_idx;
    bus.ADDR    = addr_q;
    bus.CNT     = cnt_q;
    bus.WB_ADDR = wb_addr_q;
    bus.READY   = (state_q == S_XFER);
    bus.MLS0    = (state_q == S_IDLE) || (state_q == S_DONE);
    bus.MLS1    = (state_q == S_XFER) && one_left;
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomized bench for ldm_stm_sequencer against a list/arithmetic reference model.
module tb_ldm_stm_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  ldm_stm_sequencer_if #(.ADDR_W(32)) bus ();

  ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_reg"},   32'(bus.REG_NUM), 32'd0);
    chk({tag, "_addr"},  bus.ADDR,         32'd0);
    chk({tag, "_cnt"},   32'(bus.CNT),     32'd0);
    chk({tag, "_wb"},    bus.WB_ADDR,      32'd0);
    chk({tag, "_ready"}, 32'(bus.READY),   32'd0);
    chk({tag, "_mls0"},  32'(bus.MLS0),    32'd1);
    chk({tag, "_mls1"},  32'(bus.MLS1),    32'd0);
  endtask

  // Full LDM/STM sequence: model derives the register order and address range
  // straight from the addressing-mode rules, then every step is compared.
  task automatic run_seq(input logic [31:0] ir, input logic [31:0] base, input bit gaps);
    logic [15:0] lst;
    int          n;
    int          regs[$];
    logic [31:0] span, start, wb;
    lst  = ir[15:0];
    n    = $countones(lst);
    span = 32'(n * 4);
    wb   = ir[23] ? base + span : base - span;
    case ({ir[24], ir[23]})
      2'b01:   start = base;
      2'b11:   start = base + 32'd4;
      2'b00:   start = base - span + 32'd4;
      default: start = base - span;
    endcase
    for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);

    bus.IR   = ir;
    bus.BASE = base;
    bus.LOAD = 1'b1;
    bus.STEP = 1'($urandom_range(0, 1));
    tick();
    bus.LOAD = 1'b0;
    chk("calc_mls0",  32'(bus.MLS0),  32'd0);
    chk("calc_ready", 32'(bus.READY), 32'd0);
    chk("calc_mls1",  32'(bus.MLS1),  32'd0);
    bus.STEP = 1'($urandom_range(0, 1));
    tick();
    bus.STEP = 1'b0;

    for (int k = 0; k < n; k++) begin
      int gap;
      gap = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g <= gap; g++) begin
        chk("xfer_ready", 32'(bus.READY),   32'd1);
        chk("xfer_mls0",  32'(bus.MLS0),    32'd0);
        chk("xfer_reg",   32'(bus.REG_NUM), 32'(regs[k]));
        chk("xfer_addr",  bus.ADDR,         start + 32'(k * 4));
        chk("xfer_mls1",  32'(bus.MLS1),    32'(k == n - 1));
        chk("xfer_cnt",   32'(bus.CNT),     32'(n));
        chk("xfer_wb",    bus.WB_ADDR,      wb);
        if (g < gap) tick();
      end
      bus.STEP = 1'b1;
      tick();
      bus.STEP = 1'b0;
    end

    chk("done_mls0",  32'(bus.MLS0),    32'd1);
    chk("done_ready", 32'(bus.READY),   32'd0);
    chk("done_mls1",  32'(bus.MLS1),    32'd0);
    chk("done_cnt",   32'(bus.CNT),     32'(n));
    chk("done_wb",    bus.WB_ADDR,      wb);
    chk("done_addr",  bus.ADDR,         start + span);
    bus.STEP = 1'($urandom_range(0, 1));
    tick();
    chk("idle_mls0",  32'(bus.MLS0),    32'd1);
    chk("idle_ready", 32'(bus.READY),   32'd0);
    chk("idle_cnt",   32'(bus.CNT),     32'(n));
    chk("idle_wb",    bus.WB_ADDR,      wb);
    chk("idle_addr",  bus.ADDR,         start + span);
    tick();
    bus.STEP = 1'b0;
    chk("idle2_mls0", 32'(bus.MLS0),    32'd1);
    chk("idle2_addr", bus.ADDR,         start + span);
  endtask

  initial begin
    RESET    = 1'b1;
    bus.LOAD = 1'b0;
    bus.STEP = 1'b0;
    bus.IR   = 32'd0;
    bus.BASE = 32'd0;
    tick();
    tick();
    chk_reset_vals("rst");
    RESET = 1'b0;
    tick();
    chk("rst_idle_mls0", 32'(bus.MLS0), 32'd1);

    // Directed addressing modes and boundaries.
    run_seq(32'h0080_0005, 32'h0000_0100, 1'b0);  // IA
    run_seq(32'h0100_8001, 32'h0000_0200, 1'b0);  // DB
    run_seq(32'h0180_FFFF, 32'h0000_0000, 1'b0);  // IB full list
    run_seq(32'h0080_0000, 32'h0000_0300, 1'b0);  // empty list
    run_seq(32'h0000_0007, 32'h0000_0004, 1'b0);  // DA with wrap

    // Abort mid-XFER: LOAD and STEP together, LOAD wins.
    bus.IR = 32'h0080_00F0; bus.BASE = 32'h0000_1000; bus.LOAD = 1'b1;
    tick();
    bus.LOAD = 1'b0;
    tick();
    chk("ab_reg0",  32'(bus.REG_NUM), 32'd4);
    chk("ab_addr0", bus.ADDR,         32'h0000_1000);
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("ab_reg1",  32'(bus.REG_NUM), 32'd5);
    bus.IR = 32'h0080_0002; bus.BASE = 32'h0000_0040;
    bus.LOAD = 1'b1; bus.STEP = 1'b1;
    tick();
    bus.LOAD = 1'b0; bus.STEP = 1'b0;
    chk("ab_calc_mls0",  32'(bus.MLS0),  32'd0);
    chk("ab_calc_ready", 32'(bus.READY), 32'd0);
    tick();
    chk("ab_ready", 32'(bus.READY),   32'd1);
    chk("ab_reg",   32'(bus.REG_NUM), 32'd1);
    chk("ab_addr",  bus.ADDR,         32'h0000_0040);
    chk("ab_cnt",   32'(bus.CNT),     32'd1);
    chk("ab_mls1",  32'(bus.MLS1),    32'd1);
    chk("ab_wb",    bus.WB_ADDR,      32'h0000_0044);
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("ab_done_mls0", 32'(bus.MLS0), 32'd1);
    chk("ab_done_addr", bus.ADDR,      32'h0000_0044);
    tick();

    // Reset during XFER.
    bus.IR = 32'h0080_0003; bus.BASE = 32'h0000_0500; bus.LOAD = 1'b1;
    tick();
    bus.LOAD = 1'b0;
    tick();
    chk("mrst_pre_ready", 32'(bus.READY), 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_vals("mrst");
    bus.STEP = 1'b1;
    tick();
    bus.STEP = 1'b0;
    chk("mrst_idle_ready", 32'(bus.READY), 32'd0);
    chk("mrst_idle_mls0",  32'(bus.MLS0),  32'd1);

    // Randomized sequences.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ir;
      int          sel;
      ir  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      ir[15:0] = 16'h0000;
      else if (sel == 1) ir[15:0] = 16'hFFFF;
      else if (sel < 5)  ir[15:0] = 16'($urandom & $urandom & $urandom);
      run_seq(ir, $urandom, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
